// File: rtl/quad_input_conditioner.sv
// Rotary-encoder front end: synchronises and debounces raw A/B pins, then flags each
// accepted state change and any step where both channels move at once.
module quad_input_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       quadA_raw,
    input  logic       quadB_raw,
    output logic       quadA,
    output logic       quadB,
    output logic       change,
    output logic       error,
    output logic [7:0] error_count
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Channel index 0 is A, 1 is B throughout.
    logic [1:0]                  raw;
    logic [1:0][SYNC_STAGES-1:0] sync_q;
    logic [1:0]                  synced;

    logic [1:0][CNT_W-1:0]       cnt_q, cnt_d;
    logic [1:0]                  level_q, level_d;
    logic [1:0]                  accept;

    logic                        change_q, change_d;
    logic                        error_q, error_d;
    logic [7:0]                  err_cnt_q, err_cnt_d;

    assign raw = {quadB_raw, quadA_raw};

    always_comb begin
        for (int ch = 0; ch < 2; ch++) begin
            synced[ch] = sync_q[ch][SYNC_STAGES-1];
        end
    end

    // NOTE: every signal gets its hold value before any branch, so no path leaves one unassigned (no latch).
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        accept  = '0;
        for (int ch = 0; ch < 2; ch++) begin
            if (synced[ch] == level_q[ch]) begin
                cnt_d[ch] = '0;
            end else if (cnt_q[ch] == CNT_LAST) begin
                level_d[ch] = synced[ch];
                cnt_d[ch]   = '0;
                accept[ch]  = 1'b1;
            end else begin
                cnt_d[ch] = cnt_q[ch] + 1'b1;
            end
        end
    end

    // Both channels accepted on one edge is an illegal Gray step.
    always_comb begin
        change_d  = |accept;
        error_d   = &accept;
        err_cnt_d = err_cnt_q;
        if (error_d && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q    <= '0;
            cnt_q     <= '0;
            level_q   <= '0;
            change_q  <= 1'b0;
            error_q   <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                sync_q[ch] <= {sync_q[ch][SYNC_STAGES-2:0], raw[ch]};
            end
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            change_q  <= change_d;
            error_q   <= error_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign quadA       = level_q[0];
    assign quadB       = level_q[1];
    assign change      = change_q;
    assign error       = error_q;
    assign error_count = err_cnt_q;

endmodule

// File: tb/tb_quad_input_conditioner.sv
// Bench for quad_input_conditioner with SYNC_STAGES=2, DEBOUNCE_CYCLES=4: run-length
// reference model feeding an event scoreboard, plus table vectors and corner sequences.
module tb_quad_input_conditioner;

    logic       clk;
    logic       reset;
    logic       quadA_raw;
    logic       quadB_raw;
    logic       quadA;
    logic       quadB;
    logic       change;
    logic       error;
    logic [7:0] error_count;

    quad_input_conditioner #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .quadA_raw  (quadA_raw),
        .quadB_raw  (quadB_raw),
        .quadA      (quadA),
        .quadB      (quadB),
        .change     (change),
        .error      (error),
        .error_count(error_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit rst;
        bit a;
        bit b;
        int hold;
        bit exp_a;
        bit exp_b;
    } vec_t;

    typedef struct {
        int     edge_no;
        bit [1:0] mask;
        bit [1:0] val;
    } ev_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   edge_n = 0;
    int   n_chg_seen = 0;
    int   n_err_seen = 0;

    ev_t  sb_q[$];
    bit [1:0] m_run_val;
    bit [1:0] m_tgt;
    bit [1:0] m_q;
    int   m_run_len[2];
    int   m_run_start[2];
    int   m_cnt;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One rising edge: drive inputs, update the model, then compare every output.
    task automatic cycle(input bit a, input bit b, input bit r);
        int       e;
        bit [1:0] rv;
        bit       exp_chg;
        bit       exp_err;
        bit       sched;
        ev_t      ev;
        @(negedge clk);
        quadA_raw = a;
        quadB_raw = b;
        reset     = r;
        e  = edge_n + 1;
        rv = {b, a};
        ev = '{edge_no: 0, mask: 2'b00, val: 2'b00};
        sched = 1'b0;
        if (r) begin
            sb_q.delete();
            m_run_val = '0;
            m_tgt     = '0;
            m_q       = '0;
            m_cnt     = 0;
            for (int ch = 0; ch < 2; ch++) begin
                m_run_len[ch]   = 100;
                m_run_start[ch] = 0;
            end
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                if (rv[ch] != m_run_val[ch]) begin
                    m_run_val[ch]   = rv[ch];
                    m_run_len[ch]   = 1;
                    m_run_start[ch] = e;
                end else if (m_run_len[ch] < 100) begin
                    m_run_len[ch]++;
                end
                // Four stable raw samples commit the level; it shows two sync edges later.
                if (m_run_len[ch] == 4 && m_run_val[ch] != m_tgt[ch]) begin
                    sched          = 1'b1;
                    ev.edge_no     = m_run_start[ch] + 5;
                    ev.mask[ch]    = 1'b1;
                    ev.val[ch]     = m_run_val[ch];
                    m_tgt[ch]      = m_run_val[ch];
                end
            end
            if (sched) sb_q.push_back(ev);
        end
        @(posedge clk);
        edge_n = e;
        #1;
        exp_chg = 1'b0;
        exp_err = 1'b0;
        if (!r && sb_q.size() > 0 && sb_q[0].edge_no == e) begin
            ev = sb_q.pop_front();
            for (int ch = 0; ch < 2; ch++) begin
                if (ev.mask[ch]) m_q[ch] = ev.val[ch];
            end
            exp_chg = 1'b1;
            exp_err = &ev.mask;
            if (exp_err && m_cnt < 255) m_cnt++;
        end
        check("quadA", quadA, m_q[0]);
        check("quadB", quadB, m_q[1]);
        check("change", change, exp_chg);
        check("error", error, exp_err);
        check("error_count", error_count, m_cnt);
        if (change === 1'b1) n_chg_seen++;
        if (error === 1'b1) n_err_seen++;
    endtask

    initial begin
        reset     = 1'b1;
        quadA_raw = 1'b0;
        quadB_raw = 1'b0;

        // Reset held with raw=11: outputs stay zero; after release both rise on edge 6.
        repeat (3) cycle(1'b1, 1'b1, 1'b1);
        check("rst_quadA", quadA, 1'b0);
        check("rst_count", error_count, 8'd0);
        n_chg_seen = 0;
        for (int k = 1; k <= 6; k++) begin
            cycle(1'b1, 1'b1, 1'b0);
            if (k == 5) check("rel_quadA_e5", quadA, 1'b0);
        end
        check("rel_quadA_e6", quadA, 1'b1);
        check("rel_quadB_e6", quadB, 1'b1);
        check("rel_change_e6", change, 1'b1);
        repeat (3) cycle(1'b1, 1'b1, 1'b0);
        check("rel_one_change", n_chg_seen, 1);

        repeat (2) cycle(1'b0, 1'b0, 1'b1);
        repeat (3) cycle(1'b0, 1'b0, 1'b0);

        // Clean A edge, B glitch rejection, 4-cycle B pulse, bounce pattern.
        vecs.push_back('{0, 1, 0, 8, 1, 0});
        vecs.push_back('{0, 1, 1, 3, 1, 0});
        vecs.push_back('{0, 1, 0, 8, 1, 0});
        vecs.push_back('{0, 1, 1, 4, 1, 0});
        vecs.push_back('{0, 1, 0, 2, 1, 1});
        vecs.push_back('{0, 1, 0, 8, 1, 0});
        vecs.push_back('{0, 1, 1, 1, 1, 0});
        vecs.push_back('{0, 1, 0, 1, 1, 0});
        vecs.push_back('{0, 1, 1, 1, 1, 0});
        vecs.push_back('{0, 1, 1, 1, 1, 0});
        vecs.push_back('{0, 1, 0, 1, 1, 0});
        vecs.push_back('{0, 1, 1, 1, 1, 0});
        vecs.push_back('{0, 1, 1, 1, 1, 0});
        vecs.push_back('{0, 1, 1, 1, 1, 0});
        vecs.push_back('{0, 1, 1, 1, 1, 0});
        vecs.push_back('{0, 1, 1, 2, 1, 1});
        vecs.push_back('{1, 0, 0, 2, 0, 0});
        for (int i = 0; i < vecs.size(); i++) begin
            for (int k = 0; k < vecs[i].hold; k++) begin
                cycle(vecs[i].a, vecs[i].b, vecs[i].rst);
            end
            check($sformatf("vec%0d_quadA", i), quadA, vecs[i].exp_a);
            check($sformatf("vec%0d_quadB", i), quadB, vecs[i].exp_b);
        end

        // Full CW cycle 00->01->11->10->00 (A,B), 10 cycles per step.
        n_chg_seen = 0;
        n_err_seen = 0;
        repeat (10) cycle(1'b0, 1'b1, 1'b0);
        check("cw01_quadB", quadB, 1'b1);
        repeat (10) cycle(1'b1, 1'b1, 1'b0);
        check("cw11_quadA", quadA, 1'b1);
        repeat (10) cycle(1'b1, 1'b0, 1'b0);
        check("cw10_quadB", quadB, 1'b0);
        repeat (10) cycle(1'b0, 1'b0, 1'b0);
        check("cw00_quadA", quadA, 1'b0);
        check("cw_changes", n_chg_seen, 4);
        check("cw_errors", n_err_seen, 0);

        // Simultaneous 00->11 step, then saturate the error counter.
        repeat (6) cycle(1'b1, 1'b1, 1'b0);
        check("sim_quadA", quadA, 1'b1);
        check("sim_quadB", quadB, 1'b1);
        check("sim_change", change, 1'b1);
        check("sim_error", error, 1'b1);
        check("sim_count", error_count, 8'd1);
        for (int n = 0; n < 300; n++) begin
            repeat (6) cycle(1'b0, 1'b0, 1'b0);
            repeat (6) cycle(1'b1, 1'b1, 1'b0);
        end
        check("sat_count", error_count, 8'd255);

        // Reset two cycles into an A acceptance window restarts the full latency.
        cycle(1'b0, 1'b0, 1'b1);
        repeat (2) cycle(1'b0, 1'b0, 1'b0);
        repeat (2) cycle(1'b1, 1'b0, 1'b0);
        repeat (2) cycle(1'b1, 1'b0, 1'b1);
        check("mid_rst_quadA", quadA, 1'b0);
        check("mid_rst_count", error_count, 8'd0);
        for (int k = 1; k <= 6; k++) begin
            cycle(1'b1, 1'b0, 1'b0);
            if (k < 6) check($sformatf("mid_wait%0d_quadA", k), quadA, 1'b0);
        end
        check("mid_accept_quadA", quadA, 1'b1);
        check("mid_accept_change", change, 1'b1);
        check("mid_left_queue", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
